// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared constants for the serial adder sequencer.
//   - FSM state encoding (S_IDLE / S_RUN / S_DONE)
//   - SLICE_W: width of the shared ripple-carry slice
//   - cnt_w(): slice-counter width, clog2(WIDTH/SLICE_W) with a floor of 1
package serial_add_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam int SLICE_W = 2;

  // Bits needed to count WIDTH/SLICE_W slices; never less than 1 so the
  // counter stays a legal vector when there is only one slice.
  function automatic int cnt_w(input int width);
    int n;
    int w;
    n = width / SLICE_W;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: requester <-> serial adder handshake bundle.
//   start, a, b, cin (and sub when SERIAL_ADD_SUB_EN is defined) : requester -> adder
//   busy, done, sum, cout                                        : adder -> requester
// Modports: master (requester side), slave (adder side).
// Optional macro: SERIAL_ADD_SUB_EN adds the 1-bit 'sub' request field.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_rca_2bit.sv
// rca_2bit: purely combinational 2-bit ripple-carry adder slice.
//   a, b : 2-bit addends
//   cin  : carry in
//   s    : 2-bit sum
//   cout : carry out of bit 1
module rca_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic c1;

  assign s[0] = a[0] ^ b[0] ^ cin;
  assign c1   = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
  assign s[1] = a[1] ^ b[1] ^ c1;
  assign cout = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: WIDTH-bit adder built from one shared 2-bit slice,
// stepped over WIDTH/2 cycles, least-significant slice first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus (slave): start/a/b/cin in, busy/done/sum/cout out
// busy is high in RUN, done is a one-cycle pulse in DONE; sum/cout are
// registered and only change on the RUN->DONE edge.
// Optional macro: SERIAL_ADD_SUB_EN adds bus.sub (a - b, cout = no borrow).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int CW = cnt_w(WIDTH);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_chk
    $error("serial_add_ctrl: WIDTH must be an even number >= 2");
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic            carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [1:0]       slice_s;
  logic             slice_cout;
  logic             last_s;
  logic             accept_s;
  logic [WIDTH+1:0] acc_cat_s;
  logic [WIDTH-1:0] acc_shift_s;
  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;

  rca_2bit u_slice (
    .a    (a_sh_q[1:0]),
    .b    (b_sh_q[1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Slice result enters at the top of the working register; after N
  // shifts slice 0 has reached bit 0. Concatenation keeps WIDTH=2 legal.
  assign acc_cat_s   = {slice_s, acc_q};
  assign acc_shift_s = acc_cat_s[WIDTH+1:2];

  assign last_s   = (cnt_q == CW'(N - 1));
  assign accept_s = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so cin is ignored when sub is set.
  assign b_load_s     = bus.sub ? ~bus.b : bus.b;
  assign carry_load_s = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load_s     = bus.b;
  assign carry_load_s = bus.cin;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath next values: load on accept, shift one slice per RUN cycle.
  always_comb begin
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept_s) begin
      cnt_d   = '0;
      a_sh_d  = bus.a;
      b_sh_d  = b_load_s;
      carry_d = carry_load_s;
      acc_d   = '0;
    end else if (state_q == S_RUN) begin
      cnt_d   = cnt_q + CW'(1);
      a_sh_d  = a_sh_q >> SLICE_W;
      b_sh_d  = b_sh_q >> SLICE_W;
      carry_d = slice_cout;
      acc_d   = acc_shift_s;
      if (last_s) begin
        sum_d  = acc_shift_s;
        cout_d = slice_cout;
      end else begin
        sum_d  = sum_q;
        cout_d = cout_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Outputs decoded from the next state so busy/done come straight off flops.
  always_comb begin
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl.
// Instantiates a WIDTH=8 and a WIDTH=2 adder on a shared clock and reset.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  serial_add_ctrl_if #(.WIDTH(8)) if8 ();
  serial_add_ctrl_if #(.WIDTH(2)) if2 ();

  serial_add_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_add_ctrl #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request on the 8-bit adder and waits (bounded) for done.
  // lat counts edges from the accepting edge up to the one raising done.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb,
                        output int lat, output logic [7:0] s, output logic c);
    if8.a   = av;
    if8.b   = bv;
    if8.cin = ci;
`ifdef SERIAL_ADD_SUB_EN
    if8.sub = sb;
`else
    if (sb) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    lat = 1;
    while (!if8.done && lat < 20) begin
      tick();
      lat++;
    end
    s = if8.sum;
    c = if8.cout;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    vectors++;
    if ({if8.busy, if8.done, if8.sum, if8.cout} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b, want all 0",
               if8.busy, if8.done, if8.sum, if8.cout);
    end
    vectors++;
    if ({if2.busy, if2.done, if2.sum, if2.cout} !== 5'd0) begin
      miscompares++;
      $display("FAIL reset2: got busy=%b done=%b sum=%h cout=%b, want all 0",
               if2.busy, if2.done, if2.sum, if2.cout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_timing();
    int lat;
    if8.a = 8'hFF; if8.b = 8'h01; if8.cin = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (if8.busy !== 1'b1 || if8.done !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_cycle%0d: got busy=%b done=%b, want busy=1 done=0",
                 i, if8.busy, if8.done);
      end
      tick();
    end
    vectors++;
    if (if8.done !== 1'b1 || if8.busy !== 1'b0 || if8.sum !== 8'h00 || if8.cout !== 1'b1) begin
      miscompares++;
      $display("FAIL ff_plus_01: got done=%b busy=%b sum=%h cout=%b, want 1 0 00 1",
               if8.done, if8.busy, if8.sum, if8.cout);
    end
    tick();
    vectors++;
    if (if8.done !== 1'b0 || if8.busy !== 1'b0 || if8.sum !== 8'h00 || if8.cout !== 1'b1) begin
      miscompares++;
      $display("FAIL done_pulse: got done=%b busy=%b sum=%h cout=%b, want 0 0 00 1",
               if8.done, if8.busy, if8.sum, if8.cout);
    end
    lat = 0;
  endtask

  task automatic test_operand_change();
    int lat;
    if8.a = 8'h5A; if8.b = 8'h33; if8.cin = 1'b1; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b0;
    lat = 1;
    while (!if8.done && lat < 20) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat !== 5 || if8.sum !== 8'h8E || if8.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL op_change: got lat=%0d sum=%h cout=%b, want lat=5 sum=8e cout=0",
               lat, if8.sum, if8.cout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    if8.a = 8'h5A; if8.b = 8'h33; if8.cin = 1'b1; if8.start = 1'b1;
    tick();
    if8.a = 8'h01; if8.b = 8'h01; if8.cin = 1'b0;
    lat = 1;
    while (!if8.done && lat < 20) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat !== 5 || if8.sum !== 8'h8E || if8.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first: got lat=%0d sum=%h cout=%b, want lat=5 sum=8e cout=0",
               lat, if8.sum, if8.cout);
    end
    // start still high in DONE: second add accepted at this edge
    tick();
    if8.start = 1'b0;
    vectors++;
    if (if8.busy !== 1'b1 || if8.sum !== 8'h8E) begin
      miscompares++;
      $display("FAIL b2b_restart: got busy=%b sum=%h, want busy=1 sum=8e",
               if8.busy, if8.sum);
    end
    lat = 1;
    while (!if8.done && lat < 20) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat !== 5 || if8.sum !== 8'h02 || if8.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d sum=%h cout=%b, want lat=5 sum=02 cout=0",
               lat, if8.sum, if8.cout);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [7:0] s;
    logic c;
    int dones;
    if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.sum !== 8'h00 || if8.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b, want all 0",
               if8.busy, if8.done, if8.sum, if8.cout);
    end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) rst_n = 1'b1;
      if (if8.done) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL reset_no_done: got %0d done pulses, want 0", dones);
    end
    do_op8(8'h10, 8'h20, 1'b0, 1'b0, lat, s, c);
    vectors++;
    if (lat !== 5 || s !== 8'h30 || c !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset: got lat=%0d sum=%h cout=%b, want lat=5 sum=30 cout=0",
               lat, s, c);
    end
    tick();
  endtask

  task automatic test_misc_adds();
    int lat;
    logic [7:0] s;
    logic c;
    do_op8(8'h80, 8'h80, 1'b1, 1'b0, lat, s, c);
    vectors++;
    if (lat !== 5 || s !== 8'h01 || c !== 1'b1) begin
      miscompares++;
      $display("FAIL add_80_80_1: got lat=%0d sum=%h cout=%b, want lat=5 sum=01 cout=1",
               lat, s, c);
    end
    tick();
    do_op8(8'hFF, 8'hFF, 1'b1, 1'b0, lat, s, c);
    vectors++;
    if (lat !== 5 || s !== 8'hFF || c !== 1'b1) begin
      miscompares++;
      $display("FAIL add_ff_ff_1: got lat=%0d sum=%h cout=%b, want lat=5 sum=ff cout=1",
               lat, s, c);
    end
    tick();
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int lat;
    logic [7:0] s;
    logic c;
    do_op8(8'h10, 8'h01, 1'b1, 1'b1, lat, s, c);
    vectors++;
    if (lat !== 5 || s !== 8'h0F || c !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_10_01: got lat=%0d sum=%h cout=%b, want lat=5 sum=0f cout=1",
               lat, s, c);
    end
    tick();
    do_op8(8'h00, 8'h01, 1'b0, 1'b1, lat, s, c);
    vectors++;
    if (lat !== 5 || s !== 8'hFF || c !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_00_01: got lat=%0d sum=%h cout=%b, want lat=5 sum=ff cout=0",
               lat, s, c);
    end
    tick();
    if8.sub = 1'b0;
  endtask
`endif

  task automatic test_width2();
    int lat;
    logic [2:0] exp;
    for (int av = 0; av < 4; av++) begin
      for (int bv = 0; bv < 4; bv++) begin
        for (int ci = 0; ci < 2; ci++) begin
          exp = 3'(av + bv + ci);
          if2.a = 2'(av); if2.b = 2'(bv); if2.cin = 1'(ci);
`ifdef SERIAL_ADD_SUB_EN
          if2.sub = 1'b0;
`endif
          if2.start = 1'b1;
          tick();
          if2.start = 1'b0;
          lat = 1;
          while (!if2.done && lat < 20) begin
            tick();
            lat++;
          end
          vectors++;
          if (lat !== 2 || {if2.cout, if2.sum} !== exp) begin
            miscompares++;
            $display("FAIL w2_%0d_%0d_%0d: got lat=%0d cout,sum=%b, want lat=2 cout,sum=%b",
                     av, bv, ci, lat, {if2.cout, if2.sum}, exp);
          end
          tick();
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    if8.start = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0;
    if2.start = 1'b0; if2.a = 2'b00; if2.b = 2'b00; if2.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    if8.sub = 1'b0;
    if2.sub = 1'b0;
`endif
    test_reset();
    test_basic_timing();
    test_operand_change();
    test_back_to_back();
    test_reset_mid();
    test_misc_adds();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    test_width2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that computes a WIDTH-bit add by reusing one 2-bit ripple-carry adder slice (rca_2bit) over WIDTH/2 cycles, least-significant slice first.
- A registered carry links each slice to the next.
- Trades latency for area. It sits between a requester using a start/done handshake and the shared narrow adder datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; must be an even number of at least 2 (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; a, b and cin are sampled when it is accepted
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to slice 0
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; sum and cout are valid
- sum  output  WIDTH  registered result; holds until the next completion
- cout  output  1  registered carry-out of the top slice

Behaviour:
- Clock and reset:
  - One clock domain: clk. Reset is asynchronous and active-low (rst_n).
  - Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Slice counter, operand shift registers and carry register are all cleared.
- States: IDLE, RUN, DONE.
  - busy = (state==RUN).
  - done = (state==DONE).
- IDLE:
  - start=1 at edge E0 latches a, b and cin (into the carry register), clears the counter, and moves to RUN.
  - start=0 stays in IDLE.
- RUN:
  - Each cycle, slice k (k = 0..N-1, N=WIDTH/2) adds a_sh[1:0] + b_sh[1:0] + carry.
  - At the edge: the 2-bit slice sum shifts into the top of the working result register, a_sh and b_sh shift right by 2, carry takes the slice Cout, and the counter increments.
  - At the edge that completes slice N-1 (E0+N): sum is loaded from the working register, cout from the slice Cout, and the state moves to DONE.
- DONE: lasts exactly one cycle.
  - start=1: accepted exactly as in IDLE (back-to-back, next RUN begins).
  - start=0: returns to IDLE.
- Latency: done is high in the cycle after edge E0+N. Throughput is one add per N+1 cycles.
- start while in RUN is ignored. There is no queuing and operands are not re-sampled.
- sum and cout change only on the RUN→DONE edge. Inputs a, b and cin may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH, with the carry out of bit WIDTH-1 reported on cout. Overflow wraps silently.
- WIDTH=2 case: N=1; RUN lasts one cycle.
- Reset mid-operation: immediate abort to reset values. The partial result is discarded and no done pulse is generated.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with start.
  - If sub=1: b is inverted on latch, the carry register is loaded with 1 (cin ignored), and the result is a−b. In that case cout=1 means no borrow.
  - If sub=0: identical to the base behaviour.
- When undefined: no sub port; add only.

Decomposition:
- Package serial_add_pkg holds:
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - SLICE_W=2.
  - Counter-width function clog2(WIDTH/2), with a minimum of 1.
- Sub-module: the 2-bit ripple-carry adder rca_2bit, instantiated once as the combinational slice. All sequencing and registers live in serial_add_ctrl.

Test Plan (WIDTH=8 unless stated):
- Reset, then start with a=0xFF, b=0x01, cin=0 → busy high for 4 cycles, done pulse 5th cycle, sum=0x00, cout=1.
- a=0x5A, b=0x33, cin=1 → sum=0x8E, cout=0. Changing a and b after acceptance does not alter the result.
- start held high through RUN with new operands a=0x01, b=0x01 → first result only (per previous case). The second add begins only in DONE, producing sum=0x02, cout=0 four cycles later.
- Assert rst_n=0 in cycle 2 of RUN → outputs immediately zero, no done pulse. A subsequent a=0x10, b=0x20 gives sum=0x30.
- SERIAL_ADD_SUB_EN, sub=1, a=0x10, b=0x01 → sum=0x0F, cout=1. With a=0x00, b=0x01 → sum=0xFF, cout=0.
- WIDTH=2, exhaustive a, b, cin (32 cases) → sum/cout match a+b+cin; done arrives 2 cycles after start.
